mux_4to1: RTL and testbench

- 4-input, 1-output selector: routes one of four data lanes (w) to output f, chosen by a 2-bit select (s).
- Provides a zero-latency combinational result (f_comb) and a registered result (f) with a valid qualifier.
- Leaf datapath block used wherever a small 4:1 data steer is needed ahead of registered logic.

---
 rtl/mux_4to1_pkg.sv | 9 +
 rtl/mux_4to1_comb.sv | 18 +
 rtl/mux_4to1.sv | 32 +++
 tb/tb_mux_4to1.sv | 111 +++++++++++
 4 files changed

// File: rtl/mux_4to1_pkg.sv
// mux_4to1_pkg: shared select type, lane codes and lane count for the 4:1 selector
package mux_4to1_pkg;
  typedef logic [1:0] mux_sel_t;
  localparam mux_sel_t SEL_W0 = 2'd0;
  localparam mux_sel_t SEL_W1 = 2'd1;
  localparam mux_sel_t SEL_W2 = 2'd2;
  localparam mux_sel_t SEL_W3 = 2'd3;
  localparam int NUM_LANES = 4;
endpackage

// File: rtl/mux_4to1_comb.sv
// mux_4to1_comb: purely combinational lane selector
module mux_4to1_comb
  import mux_4to1_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [NUM_LANES*WIDTH-1:0] w,
  input  mux_sel_t                   s,
  output logic [WIDTH-1:0]           f
);
  // explicit compare chain so unselected X lanes never reach f when s is known
  always_comb begin
    f = (s == SEL_W0) ? w[0*WIDTH +: WIDTH] :
        (s == SEL_W1) ? w[1*WIDTH +: WIDTH] :
        (s == SEL_W2) ? w[2*WIDTH +: WIDTH] :
        (s == SEL_W3) ? w[3*WIDTH +: WIDTH] : 'x;
  end
endmodule

// File: rtl/mux_4to1.sv
// mux_4to1: 4:1 lane selector with combinational and registered outputs
module mux_4to1
  import mux_4to1_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_LANES*WIDTH-1:0] w,
  input  mux_sel_t                   s,
  input  logic                       in_valid,
  output logic [WIDTH-1:0]           f_comb,
  output logic [WIDTH-1:0]           f,
  output logic                       out_valid,
  output mux_sel_t                   s_q
);
  mux_4to1_comb #(.WIDTH(WIDTH)) u_sel (.w(w), .s(s), .f(f_comb));
  // capture the selected lane on valid, hold otherwise; valid is a one-cycle pulse per capture
  always_ff @(posedge clk) begin
    if (rst) begin
      f         <= '0;
      s_q       <= SEL_W0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        f   <= f_comb;
        s_q <= s;
      end
    end
  end
endmodule

// File: tb/tb_mux_4to1.sv
// tb_mux_4to1: table-driven check of the 4:1 selector at WIDTH=1 and WIDTH=8
module tb_mux_4to1;
  logic       clk = 1'b0;
  logic       rst1 = 1'b1, iv1 = 1'b0;
  logic [3:0] w1 = 4'bxxxx;
  logic [1:0] s1 = 2'd0;
  logic       fc1, f1, ov1;
  logic [1:0] sq1;
  logic        rst8 = 1'b1, iv8 = 1'b0;
  logic [31:0] w8 = '0;
  logic [1:0]  s8 = 2'd0;
  logic [7:0]  fc8, f8;
  logic        ov8;
  logic [1:0]  sq8;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux_4to1 #(.WIDTH(1)) u1 (.clk(clk), .rst(rst1), .w(w1), .s(s1), .in_valid(iv1),
                            .f_comb(fc1), .f(f1), .out_valid(ov1), .s_q(sq1));
  mux_4to1 #(.WIDTH(8)) u8 (.clk(clk), .rst(rst8), .w(w8), .s(s8), .in_valid(iv8),
                            .f_comb(fc8), .f(f8), .out_valid(ov8), .s_q(sq8));

  typedef struct {
    logic       rst;
    logic       iv;
    logic [3:0] w;
    logic [1:0] s;
    logic       fc;
    logic       f;
    logic [1:0] sq;
    logic       ov;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    logic       mf, mov, el;
    logic [1:0] msq;
    tbl[0]  = '{1'b1, 1'b1, 4'b1111, 2'd3, 1'b1, 1'b0, 2'd0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 4'b1111, 2'd3, 1'b1, 1'b0, 2'd0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 4'b1010, 2'd0, 1'b0, 1'b0, 2'd0, 1'b1};
    tbl[3]  = '{1'b0, 1'b1, 4'b1010, 2'd1, 1'b1, 1'b1, 2'd1, 1'b1};
    tbl[4]  = '{1'b0, 1'b1, 4'b1010, 2'd2, 1'b0, 1'b0, 2'd2, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 4'b1010, 2'd3, 1'b1, 1'b1, 2'd3, 1'b1};
    tbl[6]  = '{1'b0, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b1, 2'd1, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b1, 2'd1, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 4'b1111, 2'd2, 1'b1, 1'b1, 2'd1, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 4'b1111, 2'd3, 1'b1, 1'b0, 2'd0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b1, 2'd3, 1'b1};
    tbl[11] = '{1'b0, 1'b1, 4'b0111, 2'd3, 1'b0, 1'b0, 2'd3, 1'b1};
    tbl[12] = '{1'b0, 1'b1, 4'b1xx0, 2'd3, 1'b1, 1'b1, 2'd3, 1'b1};
    tbl[13] = '{1'b0, 1'b1, 4'bxx10, 2'd1, 1'b1, 1'b1, 2'd1, 1'b1};
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      rst1 = tbl[i].rst; iv1 = tbl[i].iv; w1 = tbl[i].w; s1 = tbl[i].s;
      #1 chk($sformatf("v%0d f_comb", i), {7'd0, fc1}, {7'd0, tbl[i].fc});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d f", i), {7'd0, f1}, {7'd0, tbl[i].f});
      chk($sformatf("v%0d s_q", i), {6'd0, sq1}, {6'd0, tbl[i].sq});
      chk($sformatf("v%0d out_valid", i), {7'd0, ov1}, {7'd0, tbl[i].ov});
    end
    mf = tbl[13].f; msq = tbl[13].sq;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      rst1 = 1'b0; w1 = 4'($urandom); s1 = 2'($urandom); iv1 = 1'($urandom);
      el = w1[s1];
      #1 chk($sformatf("rnd%0d f_comb", i), {7'd0, fc1}, {7'd0, el});
      if (iv1) begin mf = el; msq = s1; end
      mov = iv1;
      @(posedge clk);
      #1;
      chk($sformatf("rnd%0d f", i), {7'd0, f1}, {7'd0, mf});
      chk($sformatf("rnd%0d s_q", i), {6'd0, sq1}, {6'd0, msq});
      chk($sformatf("rnd%0d out_valid", i), {7'd0, ov1}, {7'd0, mov});
    end
    @(negedge clk);
    rst8 = 1'b1;
    @(posedge clk);
    #1 chk("w8 reset f", f8, 8'h00);
    @(negedge clk);
    rst8 = 1'b0; iv8 = 1'b1; w8 = {8'hDD, 8'hCC, 8'hBB, 8'hAA}; s8 = 2'd2;
    #1 chk("w8 s2 f_comb", fc8, 8'hCC);
    @(posedge clk);
    #1 chk("w8 s2 f", f8, 8'hCC);
    chk("w8 s2 s_q", {6'd0, sq8}, 8'd2);
    @(negedge clk);
    s8 = 2'd3;
    #1 chk("w8 s3 f_comb", fc8, 8'hDD);
    @(posedge clk);
    #1 chk("w8 s3 f", f8, 8'hDD);
    chk("w8 s3 out_valid", {7'd0, ov8}, 8'd1);
    @(negedge clk);
    s8 = 2'd0;
    #1 chk("w8 s0 f_comb", fc8, 8'hAA);
    s8 = 2'd1;
    #1 chk("w8 s1 f_comb", fc8, 8'hBB);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
